// File: rtl/cv32e40p_pkg.sv
// Shared types and constants for the CV32E40P instruction fetch queue.
package cv32e40p_pkg;

  localparam int unsigned FETCH_MAX_OUTSTANDING = 2;

  typedef enum logic [1:0] {
    FQ_IDLE,
    FQ_WAIT_GNT,
    FQ_WAIT_GNT_FLUSH
  } fetch_queue_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cv32e40p_fetch_fifo.sv
// Small synchronous FIFO for fetched instruction words; head is presented combinationally.
module cv32e40p_fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [WIDTH-1:0]             wdata_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   cnt_o,
  output logic                         empty_o
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0] wptr_q, wptr_d;
  logic [AddrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + AddrW'(1);
      if (pop_i)  rptr_d = rptr_q + AddrW'(1);
      if (push_i && !pop_i)      cnt_d = cnt_q + CntW'(1);
      else if (!push_i && pop_i) cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign cnt_o   = cnt_q;
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/cv32e40p_fetch_queue.sv
// Instruction fetch queue: issues OBI word fetches (max two in flight), buffers responses
// and hands them to the IF stage, discarding old-stream data on a branch.
module cv32e40p_fetch_queue
  import cv32e40p_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        fetch_ready_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_rdata_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        busy_o
);

  localparam int unsigned CntW   = $clog2(DEPTH + 1);
  localparam logic [1:0]  MaxOut = 2'(FETCH_MAX_OUTSTANDING);

  fetch_queue_state_e state_q, state_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] branch_addr_q, branch_addr_d;
  logic [1:0]  outstanding_q, outstanding_d;
  logic [1:0]  discard_q, discard_d;

  logic [CntW-1:0] fifo_cnt;
  logic [CntW:0]   level;
  logic [31:0]     fifo_rdata, branch_target;
  logic            fifo_empty, fifo_push, fifo_pop;
  logic            can_issue, branch_ok, granted, rsp_accept, bypass;
  logic            unused_err;

  assign unused_err    = instr_err_i;
  assign branch_target = word_align(branch_addr_i);
  assign level         = {1'b0, fifo_cnt} + (CntW + 1)'(outstanding_q);
  assign can_issue     = req_i && (level < (CntW + 1)'(DEPTH)) && (outstanding_q < MaxOut);
  // FIFO is flushed in the branch cycle, so only the in-flight limit gates the new target.
  assign branch_ok     = req_i && (outstanding_q < MaxOut);
  assign granted       = instr_req_o && instr_gnt_i;

  always_comb begin
    state_d       = state_q;
    fetch_addr_d  = fetch_addr_q;
    branch_addr_d = branch_addr_q;
    instr_req_o   = 1'b0;
    instr_addr_o  = fetch_addr_q;
    unique case (state_q)
      FQ_IDLE: begin
        if (branch_i) begin
          if (branch_ok) begin
            instr_req_o  = 1'b1;
            instr_addr_o = branch_target;
            if (instr_gnt_i) begin
              fetch_addr_d = branch_target + 32'd4;
            end else begin
              fetch_addr_d = branch_target;
              state_d      = FQ_WAIT_GNT;
            end
          end else begin
            fetch_addr_d = branch_target;
          end
        end else if (can_issue) begin
          instr_req_o = 1'b1;
          if (instr_gnt_i) fetch_addr_d = fetch_addr_q + 32'd4;
          else             state_d      = FQ_WAIT_GNT;
        end
      end
      FQ_WAIT_GNT: begin
        instr_req_o = 1'b1;
        if (instr_gnt_i) begin
          state_d      = FQ_IDLE;
          fetch_addr_d = branch_i ? branch_target : fetch_addr_q + 32'd4;
        end else if (branch_i) begin
          branch_addr_d = branch_target;
          state_d       = FQ_WAIT_GNT_FLUSH;
        end
      end
      FQ_WAIT_GNT_FLUSH: begin
        instr_req_o = 1'b1;
        if (branch_i) branch_addr_d = branch_target;
        if (instr_gnt_i) begin
          state_d      = FQ_IDLE;
          fetch_addr_d = branch_i ? branch_target : branch_addr_q;
        end
      end
      default: state_d = FQ_IDLE;
    endcase
  end

  // A grant outside IDLE is always for the old stream when a branch is pending or arriving.
  always_comb begin
    outstanding_d = outstanding_q + 2'(granted) - 2'(instr_rvalid_i);
    discard_d     = discard_q;
    if (branch_i) begin
      discard_d = outstanding_q + 2'(granted && (state_q != FQ_IDLE)) - 2'(instr_rvalid_i);
    end else begin
      if (instr_rvalid_i && (discard_q != 2'd0)) discard_d = discard_d - 2'd1;
      if (granted && (state_q == FQ_WAIT_GNT_FLUSH)) discard_d = discard_d + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FQ_IDLE;
      fetch_addr_q  <= '0;
      branch_addr_q <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_addr_q  <= fetch_addr_d;
      branch_addr_q <= branch_addr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  assign rsp_accept = instr_rvalid_i && (discard_q == 2'd0) && !branch_i;
  assign bypass     = fifo_empty && fetch_ready_i && rsp_accept;
  assign fifo_push  = rsp_accept && !bypass;
  assign fifo_pop   = !fifo_empty && fetch_ready_i && !branch_i;

  cv32e40p_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (branch_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (instr_rdata_i),
    .rdata_o (fifo_rdata),
    .cnt_o   (fifo_cnt),
    .empty_o (fifo_empty)
  );

  assign fetch_valid_o = fifo_empty ? rsp_accept : !branch_i;
  assign fetch_rdata_o = fifo_empty ? instr_rdata_i : fifo_rdata;
  assign busy_o        = instr_req_o || (outstanding_q != 2'd0);

endmodule

// File: tb/tb_cv32e40p_fetch_queue.sv
// Directed bench for the fetch queue: an OBI slave model with configurable response latency
// and a negedge monitor that scoreboards granted addresses and delivered words.
module tb_cv32e40p_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i, branch_i, fetch_ready_i;
  logic [31:0] branch_addr_i;
  logic        fetch_valid_o;
  logic [31:0] fetch_rdata_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i, instr_rvalid_i, instr_err_i;
  logic [31:0] instr_rdata_i;
  logic        busy_o;

  logic gnt_en;
  int   lat;
  int   cyc;
  int   n_checks;
  int   n_pass;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  cv32e40p_fetch_queue #(
    .DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .fetch_ready_i  (fetch_ready_i),
    .fetch_valid_o  (fetch_valid_o),
    .fetch_rdata_o  (fetch_rdata_o),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  assign instr_gnt_i = gnt_en;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_word(input logic [31:0] a, input bit delivered);
    exp_addr_q.push_back(a);
    if (delivered) exp_data_q.push_back(mem_word(a));
  endtask

  // Let outstanding traffic finish, then require every expectation to have been consumed.
  task automatic drain();
    for (int k = 0; k < 30; k++) begin
      tick();
      @(negedge clk);
      if (!busy_o) break;
    end
    check("drain_busy", 32'(busy_o), 32'd0);
    tick();
    @(negedge clk);
    check("addr_q_left", exp_addr_q.size(), 32'd0);
    check("data_q_left", exp_data_q.size(), 32'd0);
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  // OBI slave: responds in order, lat cycles after the grant.
  initial begin
    cyc            = 0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        pend_q.delete();
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = '0;
      end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = mem_word(pend_q[0].addr);
        void'(pend_q.pop_front());
      end else begin
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = '0;
      end
    end
  end

  // Monitor: compares every granted address and every consumed word against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (instr_req_o && instr_gnt_i) begin
          pend_q.push_back('{addr: instr_addr_o, due: cyc + lat});
          if (exp_addr_q.size() == 0) begin
            n_checks++;
            $display("FAIL req_addr: unexpected request to %h, expected none", instr_addr_o);
          end else begin
            check("req_addr", instr_addr_o, exp_addr_q.pop_front());
          end
        end
        if (fetch_valid_o && fetch_ready_i) begin
          if (exp_data_q.size() == 0) begin
            n_checks++;
            $display("FAIL fetch_word: unexpected word %h, expected none", fetch_rdata_o);
          end else begin
            check("fetch_word", fetch_rdata_o, exp_data_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    lat           = 1;
    gnt_en        = 1'b0;
    rst_n         = 1'b0;
    req_i         = 1'b0;
    branch_i      = 1'b0;
    branch_addr_i = '0;
    fetch_ready_i = 1'b0;
    instr_err_i   = 1'b0;
    repeat (3) @(posedge clk);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req", 32'(instr_req_o), 32'd0);
    check("rst_addr", instr_addr_o, 32'd0);
    check("rst_valid", 32'(fetch_valid_o), 32'd0);
    check("rst_rdata", fetch_rdata_o, 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);

    // Boot fetch from 0x80, zero-wait slave, ready consumer.
    gnt_en = 1'b1;
    fetch_ready_i = 1'b1;
    tick();
    branch_i = 1'b1;
    branch_addr_i = 32'h0000_0080;
    req_i = 1'b1;
    for (int i = 0; i < 6; i++) exp_word(32'h80 + 32'(4 * i), 1'b1);
    @(negedge clk);
    check("boot_req", 32'(instr_req_o), 32'd1);
    check("boot_addr", instr_addr_o, 32'h80);
    check("boot_valid_n", 32'(fetch_valid_o), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      branch_i = 1'b0;
      @(negedge clk);
      check("boot_stream_valid", 32'(fetch_valid_o), 32'd1);
    end
    tick();
    req_i = 1'b0;
    drain();

    // Back-pressure: two words buffered, then drained in order.
    tick();
    fetch_ready_i = 1'b0;
    req_i = 1'b1;
    exp_word(32'h98, 1'b1);
    exp_word(32'h9C, 1'b1);
    exp_word(32'hA0, 1'b1);
    tick();
    tick();
    tick();
    @(negedge clk);
    check("bp_no_req", 32'(instr_req_o), 32'd0);
    check("bp_head_valid", 32'(fetch_valid_o), 32'd1);
    check("bp_head_data", fetch_rdata_o, mem_word(32'h98));
    tick();
    @(negedge clk);
    check("bp_no_req2", 32'(instr_req_o), 32'd0);
    check("bp_busy", 32'(busy_o), 32'd0);
    tick();
    fetch_ready_i = 1'b1;
    tick();
    @(negedge clk);
    check("bp_resume_req", 32'(instr_req_o), 32'd1);
    check("bp_resume_addr", instr_addr_o, 32'hA0);
    tick();
    req_i = 1'b0;
    drain();

    // Held request with a branch to 0x200 while waiting for grant.
    tick();
    gnt_en = 1'b0;
    req_i = 1'b1;
    exp_word(32'hA4, 1'b0);
    exp_word(32'h200, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      branch_i = (i == 2);
      branch_addr_i = 32'h200;
      @(negedge clk);
      check("held_req", 32'(instr_req_o), 32'd1);
      check("held_addr", instr_addr_o, 32'hA4);
    end
    tick();
    branch_i = 1'b0;
    gnt_en = 1'b1;
    tick();
    @(negedge clk);
    check("held_old_dropped", 32'(fetch_valid_o), 32'd0);
    check("held_new_addr", instr_addr_o, 32'h200);
    tick();
    req_i = 1'b0;
    @(negedge clk);
    check("held_new_valid", 32'(fetch_valid_o), 32'd1);
    drain();

    // Flush with two responses in flight (3-cycle slave).
    lat = 3;
    tick();
    req_i = 1'b1;
    exp_word(32'h204, 1'b0);
    exp_word(32'h208, 1'b0);
    exp_word(32'h1000, 1'b1);
    tick();
    tick();
    branch_i = 1'b1;
    branch_addr_i = 32'h0000_1002;
    @(negedge clk);
    check("fl_req_blocked", 32'(instr_req_o), 32'd0);
    check("fl_valid_n", 32'(fetch_valid_o), 32'd0);
    tick();
    branch_i = 1'b0;
    @(negedge clk);
    check("fl_drop1", 32'(fetch_valid_o), 32'd0);
    tick();
    @(negedge clk);
    check("fl_drop2", 32'(fetch_valid_o), 32'd0);
    check("fl_new_req", 32'(instr_req_o), 32'd1);
    check("fl_new_addr", instr_addr_o, 32'h1000);
    tick();
    req_i = 1'b0;
    drain();
    lat = 1;

    // rvalid and branch in the same cycle; new request granted in the branch cycle.
    tick();
    req_i = 1'b1;
    exp_word(32'h1004, 1'b0);
    exp_word(32'h300, 1'b1);
    tick();
    branch_i = 1'b1;
    branch_addr_i = 32'h300;
    @(negedge clk);
    check("col_rvalid_seen", 32'(instr_rvalid_i), 32'd1);
    check("col_dropped", 32'(fetch_valid_o), 32'd0);
    check("col_new_addr", instr_addr_o, 32'h300);
    tick();
    branch_i = 1'b0;
    req_i = 1'b0;
    @(negedge clk);
    check("col_new_valid", 32'(fetch_valid_o), 32'd1);
    drain();

    // Grant and branch together while a request is held.
    tick();
    gnt_en = 1'b0;
    req_i = 1'b1;
    exp_word(32'h304, 1'b0);
    exp_word(32'h400, 1'b1);
    tick();
    gnt_en = 1'b1;
    branch_i = 1'b1;
    branch_addr_i = 32'h400;
    tick();
    branch_i = 1'b0;
    @(negedge clk);
    check("gb_dropped", 32'(fetch_valid_o), 32'd0);
    check("gb_new_addr", instr_addr_o, 32'h400);
    tick();
    req_i = 1'b0;
    @(negedge clk);
    check("gb_new_valid", 32'(fetch_valid_o), 32'd1);
    drain();

    // Wrap past 0xFFFF_FFFC and busy falling after the last response.
    tick();
    branch_i = 1'b1;
    branch_addr_i = 32'hFFFF_FFF8;
    req_i = 1'b1;
    exp_word(32'hFFFF_FFF8, 1'b1);
    exp_word(32'hFFFF_FFFC, 1'b1);
    exp_word(32'h0000_0000, 1'b1);
    tick();
    branch_i = 1'b0;
    tick();
    @(negedge clk);
    check("wrap_addr", instr_addr_o, 32'h0);
    tick();
    req_i = 1'b0;
    @(negedge clk);
    check("gate_no_req", 32'(instr_req_o), 32'd0);
    check("gate_busy_hi", 32'(busy_o), 32'd1);
    tick();
    @(negedge clk);
    check("gate_busy_lo", 32'(busy_o), 32'd0);
    drain();

    // Reset while a request is held.
    tick();
    gnt_en = 1'b0;
    req_i = 1'b1;
    tick();
    req_i = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_req", 32'(instr_req_o), 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_valid", 32'(fetch_valid_o), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_addr", instr_addr_o, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
